memory_access_unit: RTL and testbench

//  Parametrised MEM pipeline stage, successor of the fixed-latency 32-bit stage. Sits between EX and WB.

---
 rtl/memory_access_unit_if.sv | 23 ++
 rtl/memory_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// RAM-side request/ready bus of the MEM stage.
// master = memory_access_unit, slave = RAM model or arbiter.
interface memory_access_unit_if #(
    parameter int XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_write_data;
    logic [XLEN-1:0]   mem_read_data;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_write_data,
        input  mem_read_data, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_write_data,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/memory_access_unit.sv
// MEM pipeline stage: sized loads/stores over a req/ready RAM bus,
// with upstream stall, alignment/legality checks and access timeout.
module memory_access_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       data_in,
    input  logic [2:0]            funct3,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  in_MemToReg,
    input  logic                  in_RegWrite,
    input  logic                  in_RegDataSrc,
    input  logic                  in_PCSrc,
    input  logic [REG_ADDR_W-1:0] in_RegDest,
    output logic                  stall,
    output logic                  out_valid,
    output logic [XLEN-1:0]       data_out,
    output logic [XLEN-1:0]       out_AluResult,
    output logic                  fault,
    output logic                  out_MemToReg,
    output logic                  out_RegWrite,
    output logic                  out_RegDataSrc,
    output logic                  out_PCSrc,
    output logic [REG_ADDR_W-1:0] out_RegDest,
    memory_access_unit_if.master  mem
);
    localparam int SW   = XLEN / 8;
    localparam int OFFW = (XLEN == 64) ? 3 : 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_nx;
    logic            accept, is_mem, bad, f3_ok, mis, timeout;
    logic            is_b, is_h, is_w, is_d;
    logic [OFFW-1:0] off, off_q;
    logic [SW-1:0]   strb, strb_q;
    logic [XLEN-1:0] wdata, wdata_q, lane, load_val;
    logic [2:0]      f3_q;
    logic            we_q;
    logic [7:0]      cnt;

    assign accept = in_valid && (state == IDLE);
    assign is_mem = MemRead || MemWrite;
    assign off    = addr[OFFW-1:0];
    assign off_q  = out_AluResult[OFFW-1:0];
    assign is_b   = (funct3[1:0] == 2'd0);
    assign is_h   = (funct3[1:0] == 2'd1);
    assign is_w   = (funct3[1:0] == 2'd2);
    assign is_d   = (funct3[1:0] == 2'd3);

    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !MemWrite;
            3'b011:                 f3_ok = (XLEN == 64);
            3'b110:                 f3_ok = (XLEN == 64) && !MemWrite;
            default:                f3_ok = 1'b0;
        endcase
    end

    assign mis = (is_h && addr[0])
              || (is_w && (addr[1:0] != 2'b00))
              || (is_d && (addr[2:0] != 3'b000));
    assign bad = is_mem && ((MemRead && MemWrite) || !f3_ok || mis);

    // Store data is replicated so any lane selected by the strobe is correct.
    always_comb begin
        strb  = '1;
        wdata = data_in;
        unique case (1'b1)
            is_b: begin
                strb  = SW'(1) << off;
                wdata = {SW{data_in[7:0]}};
            end
            is_h: begin
                strb  = SW'(3) << off;
                wdata = {(SW/2){data_in[15:0]}};
            end
            is_w: begin
                strb  = SW'(15) << off;
                wdata = {(SW/4){data_in[31:0]}};
            end
            default: begin
                strb  = '1;
                wdata = data_in;
            end
        endcase
    end

    assign lane = mem.mem_read_data >> {off_q, 3'b000};

    always_comb begin
        load_val = '0;
        case (f3_q)
            3'b000:  load_val = XLEN'($signed(lane[7:0]));
            3'b001:  load_val = XLEN'($signed(lane[15:0]));
            3'b010:  load_val = XLEN'($signed(lane[31:0]));
            3'b100:  load_val = XLEN'(lane[7:0]);
            3'b101:  load_val = XLEN'(lane[15:0]);
            3'b110:  load_val = XLEN'(lane[31:0]);
            default: load_val = lane;
        endcase
        if (we_q) load_val = '0;
    end

    // Ready on the last allowed cycle still completes normally.
    assign timeout = (state == ACCESS) && !mem.mem_ready
                  && (cnt == 8'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mem && !bad) state_nx = ACCESS;
            ACCESS:  if (mem.mem_ready || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall              = (state == ACCESS);
        mem.mem_req        = stall;
        mem.mem_we         = stall && we_q;
        mem.mem_addr       = '0;
        mem.mem_wstrb      = '0;
        mem.mem_write_data = '0;
        if (stall) begin
            mem.mem_addr       = {out_AluResult[XLEN-1:OFFW], OFFW'(0)};
            mem.mem_wstrb      = strb_q;
            mem.mem_write_data = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            data_out       <= '0;
            out_AluResult  <= '0;
            fault          <= 1'b0;
            out_MemToReg   <= 1'b0;
            out_RegWrite   <= 1'b0;
            out_RegDataSrc <= 1'b0;
            out_PCSrc      <= 1'b0;
            out_RegDest    <= '0;
            we_q           <= 1'b0;
            f3_q           <= '0;
            strb_q         <= '0;
            wdata_q        <= '0;
            cnt            <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                out_AluResult  <= addr;
                out_MemToReg   <= in_MemToReg;
                out_RegWrite   <= in_RegWrite && !bad;
                out_RegDataSrc <= in_RegDataSrc;
                out_PCSrc      <= in_PCSrc;
                out_RegDest    <= in_RegDest;
                we_q           <= MemWrite;
                f3_q           <= funct3;
                strb_q         <= MemWrite ? strb : '1;
                wdata_q        <= wdata;
                cnt            <= '0;
                if (!is_mem || bad) begin
                    out_valid <= 1'b1;
                    data_out  <= '0;
                    fault     <= bad;
                end
            end
            if (state == ACCESS) begin
                if (mem.mem_ready) begin
                    out_valid <= 1'b1;
                    data_out  <= load_val;
                    fault     <= 1'b0;
                end else if (timeout) begin
                    out_valid    <= 1'b1;
                    data_out     <= '0;
                    fault        <= 1'b1;
                    out_RegWrite <= 1'b0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit (XLEN=32, WAIT_MAX=4).
// Stimulus pushes expected WB bundles; a negedge monitor pops and compares.
module tb_memory_access_unit;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int WM   = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] alu;
        logic        flt;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [2:0] funct3 = '0;
    logic MemRead = 1'b0;
    logic MemWrite = 1'b0;
    logic in_MemToReg = 1'b0;
    logic in_RegWrite = 1'b0;
    logic in_RegDataSrc = 1'b0;
    logic in_PCSrc = 1'b0;
    logic [RW-1:0] in_RegDest = '0;
    logic stall, out_valid, fault;
    logic [31:0] data_out, out_AluResult;
    logic out_MemToReg, out_RegWrite, out_RegDataSrc, out_PCSrc;
    logic [RW-1:0] out_RegDest;

    exp_t exp_q[$];
    exp_t e_mon, a_mon;
    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt = 0;
    int cyc;
    int base;

    memory_access_unit_if #(.XLEN(XLEN)) bus ();

    memory_access_unit #(
        .XLEN(XLEN), .REG_ADDR_W(RW), .WAIT_MAX(WM)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .addr(addr), .data_in(data_in), .funct3(funct3),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite),
        .in_RegDataSrc(in_RegDataSrc), .in_PCSrc(in_PCSrc),
        .in_RegDest(in_RegDest), .stall(stall),
        .out_valid(out_valid), .data_out(data_out),
        .out_AluResult(out_AluResult), .fault(fault),
        .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite),
        .out_RegDataSrc(out_RegDataSrc), .out_PCSrc(out_PCSrc),
        .out_RegDest(out_RegDest), .mem(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (stall) stall_cnt++;

    always @(negedge clk) begin
        if (rst && out_valid) begin
            n_cmp++;
            a_mon = '{data: data_out, alu: out_AluResult, flt: fault,
                      ctrl: {out_MemToReg, out_RegWrite,
                             out_RegDataSrc, out_PCSrc},
                      rd: out_RegDest};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_pulse: unexpected out_valid alu=%h, required none",
                         out_AluResult);
            end else begin
                e_mon = exp_q.pop_front();
                if (a_mon !== e_mon) begin
                    n_err++;
                    $display("FAIL wb_bundle alu=%h: got data=%h flt=%b ctrl=%b rd=%0d, required data=%h alu=%h flt=%b ctrl=%b rd=%0d",
                             a_mon.alu, a_mon.data, a_mon.flt, a_mon.ctrl, a_mon.rd,
                             e_mon.data, e_mon.alu, e_mon.flt, e_mon.ctrl, e_mon.rd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Drive an op at a negedge and hold it until the DUT accepts it.
    task automatic present(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input logic r, input logic w,
                           input logic rw, input logic [4:0] rdst,
                           input logic [31:0] xdata, input logic xflt,
                           input bit push);
        exp_t x;
        bit acc;
        int n;
        in_valid = 1'b1; addr = a; data_in = d; funct3 = f3;
        MemRead = r; MemWrite = w; in_MemToReg = r; in_RegWrite = rw;
        in_RegDataSrc = rdst[0]; in_PCSrc = rdst[1]; in_RegDest = rdst;
        x = '{data: xdata, alu: a, flt: xflt,
              ctrl: {r, rw & ~xflt, rdst[0], rdst[1]}, rd: rdst};
        if (push) exp_q.push_back(x);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            acc = !stall;
            @(negedge clk);
            n++;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got stall held, required accept");
        end
    endtask

    // Answer the pending RAM access after nw wait cycles.
    task automatic serve(input int nw, input logic [31:0] rdata, output int c);
        c = 0;
        while (stall && c < 40) begin
            bus.mem_ready = (c == nw);
            bus.mem_read_data = rdata;
            c++;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] x;
    } ld_t;

    ld_t lds[5] = '{
        '{32'h5002, 3'b001, 32'h8001_0000, 32'hFFFF_8001},
        '{32'h5002, 3'b101, 32'h8001_0000, 32'h0000_8001},
        '{32'h5001, 3'b100, 32'h0000_F000, 32'h0000_00F0},
        '{32'h6000, 3'b010, 32'hCAFE_BABE, 32'hCAFE_BABE},
        '{32'h6001, 3'b000, 32'h0000_7F00, 32'h0000_007F}
    };

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_read_data = '0;
        #12;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_fault", {data_out[30:0], fault}, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // LB sign, 3 waits: ready lands on the timeout cycle and wins
        present(32'h1003, 0, 3'b000, 1, 0, 1, 5'd5, 32'hFFFF_FF80, 0, 1);
        in_valid = 1'b0;
        chk("lb_mem_req", bus.mem_req, 1);
        chk("lb_mem_addr", bus.mem_addr, 32'h1000);
        chk("lb_wstrb", bus.mem_wstrb, 4'hF);
        serve(3, 32'h80FF_FF00, cyc);
        chk("lb_stall_cycles", cyc, 4);

        // SH to upper half
        present(32'h2002, 32'h1234_ABCD, 3'b001, 0, 1, 0, 5'd3, 0, 0, 1);
        in_valid = 1'b0;
        chk("sh_we", bus.mem_we, 1);
        chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
        chk("sh_wdata", bus.mem_write_data, 32'hABCD_ABCD);
        chk("sh_addr", bus.mem_addr, 32'h2000);
        serve(0, 32'hDEAD_BEEF, cyc);
        chk("sh_stall_cycles", cyc, 1);

        // SB and SW strobes
        present(32'h7001, 32'h0000_0055, 3'b000, 0, 1, 0, 5'd2, 0, 0, 1);
        in_valid = 1'b0;
        chk("sb_wstrb", bus.mem_wstrb, 4'b0010);
        chk("sb_wdata", bus.mem_write_data, 32'h5555_5555);
        serve(1, 0, cyc);
        present(32'h7004, 32'h0102_0304, 3'b010, 0, 1, 0, 5'd2, 0, 0, 1);
        in_valid = 1'b0;
        chk("sw_wstrb", bus.mem_wstrb, 4'hF);
        chk("sw_wdata", bus.mem_write_data, 32'h0102_0304);
        serve(0, 0, cyc);

        // misaligned LW
        present(32'h3001, 0, 3'b010, 1, 0, 1, 5'd9, 0, 1, 1);
        in_valid = 1'b0;
        chk("mis_mem_req", bus.mem_req, 0);
        chk("mis_out_valid", out_valid, 1);

        // illegal encodings
        present(32'h7000, 32'h11, 3'b100, 0, 1, 0, 5'd1, 0, 1, 1);
        in_valid = 1'b0;
        chk("ill_sbu_req", bus.mem_req, 0);
        present(32'h7000, 0, 3'b011, 1, 0, 1, 5'd1, 0, 1, 1);
        in_valid = 1'b0;
        chk("ill_ld_req", bus.mem_req, 0);
        present(32'h7000, 0, 3'b010, 1, 1, 1, 5'd1, 0, 1, 1);
        in_valid = 1'b0;
        chk("ill_rw_req", bus.mem_req, 0);
        present(32'h7000, 0, 3'b111, 1, 0, 1, 5'd1, 0, 1, 1);
        in_valid = 1'b0;
        chk("ill_111_req", bus.mem_req, 0);

        // load extraction table
        foreach (lds[i]) begin
            present(lds[i].a, 0, lds[i].f3, 1, 0, 1, 5'(10 + i), lds[i].x, 0, 1);
            in_valid = 1'b0;
            serve(i % 3, lds[i].rdata, cyc);
            chk("ld_stall_cycles", cyc, 32'(i % 3 + 1));
        end

        // timeout
        present(32'h4000, 0, 3'b010, 1, 0, 1, 5'd12, 0, 1, 1);
        in_valid = 1'b0;
        serve(100, 0, cyc);
        chk("to_stall_cycles", cyc, WM);
        chk("to_mem_req", bus.mem_req, 0);

        // back-to-back ALU, LW, ALU with ready held high (also idle-ready)
        @(negedge clk);
        base = stall_cnt;
        bus.mem_ready = 1'b1;
        bus.mem_read_data = 32'h1357_2468;
        present(32'hAAAA, 0, 3'b000, 0, 0, 1, 5'd7, 0, 0, 1);
        present(32'h8000, 0, 3'b010, 1, 0, 1, 5'd8, 32'h1357_2468, 0, 1);
        present(32'hBBBB, 0, 3'b000, 0, 0, 1, 5'd6, 0, 0, 1);
        in_valid = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_stall_cycles", stall_cnt - base, 1);

        // reset in the middle of an access
        present(32'h9000, 0, 3'b010, 1, 0, 1, 5'd4, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_req_before", bus.mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_mem_req", bus.mem_req, 0);
        chk("rstmid_stall", stall, 0);
        chk("rstmid_out_valid", out_valid, 0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_idle", {bus.mem_req, stall}, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end
endmodule
